warp_barrier_ctl: RTL

- Responder end of the per-warp barrier request (valid, id, is_global, size_m1, is_noop) issued by warp control on a barrier instruction.
- Tracks arrivals per barrier id and holds the arriving warps stalled.
- Releases the collected warp mask to the scheduler when the barrier completes.
- Global barriers finish their local phase here, then hand off to the cluster-level barrier over a request/response pair.

---
 rtl/warp_barrier_ctl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/warp_barrier_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : warp_barrier_ctl
//  Description : Per-core warp barrier controller. Collects warp arrivals
//                per barrier id, holds arriving warps stalled, releases the
//                collected mask when the barrier completes, and hands global
//                barriers off to the cluster barrier over a req/rsp pair.
//  Revision    : 1.0 - initial release
// ============================================================================
module warp_barrier_ctl #(
    parameter int NUM_WARPS    = 4,
    parameter int NUM_BARRIERS = 4,
    parameter int NUM_CORES    = 4,
    parameter int NW_WIDTH     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int NB_WIDTH     = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1,
    parameter int NC_WIDTH     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
    parameter int SZ_WIDTH     = (NW_WIDTH > NC_WIDTH) ? NW_WIDTH : NC_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,

    // Arrival request from warp control
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [NW_WIDTH-1:0]  req_wid,
    input  logic [NB_WIDTH-1:0]  req_id,
    input  logic                 req_is_global,
    input  logic [SZ_WIDTH-1:0]  req_size_m1,
    input  logic                 req_is_noop,

    // Release to the scheduler
    output logic                 release_valid,
    output logic [NUM_WARPS-1:0] release_wmask,
    output logic [NUM_WARPS-1:0] stalled_wmask,

    // Cluster-level barrier handshake
    output logic                 gbar_req_valid,
    input  logic                 gbar_req_ready,
    output logic [NB_WIDTH-1:0]  gbar_req_id,
    output logic [SZ_WIDTH-1:0]  gbar_req_size_m1,
    input  logic                 gbar_rsp_valid,
    input  logic [NB_WIDTH-1:0]  gbar_rsp_id
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_GREQ    = 2'd2,
        ST_GWAIT   = 2'd3
    } state_e;

    // Per-barrier entry state
    state_e                state_q  [NUM_BARRIERS];
    state_e                state_d  [NUM_BARRIERS];
    logic [NW_WIDTH:0]     count_q  [NUM_BARRIERS];
    logic [NW_WIDTH:0]     count_d  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]  wmask_q  [NUM_BARRIERS];
    logic [NUM_WARPS-1:0]  wmask_d  [NUM_BARRIERS];
    logic                  glob_q   [NUM_BARRIERS];
    logic                  glob_d   [NUM_BARRIERS];
    logic [SZ_WIDTH-1:0]   size_q   [NUM_BARRIERS];
    logic [SZ_WIDTH-1:0]   size_d   [NUM_BARRIERS];

    // Registered release outputs
    logic                  rel_valid_q;
    logic                  rel_valid_d;
    logic [NUM_WARPS-1:0]  rel_mask_q;
    logic [NUM_WARPS-1:0]  rel_mask_d;

    // Combinational helpers
    logic                  w_ready;
    logic                  w_accept;
    logic [NUM_WARPS-1:0]  w_wid_onehot;
    logic                  w_gsel_found;
    logic [NB_WIDTH-1:0]   w_gsel_id;
    logic [SZ_WIDTH-1:0]   w_gsel_size;
    logic [NUM_WARPS-1:0]  w_stalled;

    assign w_wid_onehot = NUM_WARPS'(1) << req_wid;

    // Arrivals are back-pressured only while the addressed id is in its global phase
    always_comb begin
        w_ready = 1'b1;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if ((req_id == NB_WIDTH'(b)) &&
                ((state_q[b] == ST_GREQ) || (state_q[b] == ST_GWAIT))) begin
                w_ready = 1'b0;
            end
        end
    end

    assign w_accept = req_valid && w_ready;

    // Fixed-priority pick of the lowest id waiting to present a global request
    always_comb begin
        w_gsel_found = 1'b0;
        w_gsel_id    = '0;
        w_gsel_size  = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            if (!w_gsel_found && (state_q[b] == ST_GREQ)) begin
                w_gsel_found = 1'b1;
                w_gsel_id    = NB_WIDTH'(b);
                w_gsel_size  = size_q[b];
            end
        end
    end

    // Stalled warps are exactly the union of all collected entry masks
    always_comb begin
        w_stalled = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            w_stalled = w_stalled | wmask_q[b];
        end
    end

    // Next-state for every entry plus the release pulse
    always_comb begin
        rel_valid_d = 1'b0;
        rel_mask_d  = '0;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            state_d[b] = state_q[b];
            count_d[b] = count_q[b];
            wmask_d[b] = wmask_q[b];
            glob_d[b]  = glob_q[b];
            size_d[b]  = size_q[b];
        end

        for (int b = 0; b < NUM_BARRIERS; b++) begin
            logic                 eff_glob;
            logic [SZ_WIDTH-1:0]  eff_size;
            logic [NUM_WARPS-1:0] new_mask;
            int                   thresh;

            // Flags come from the first arrival; later arrivals reuse the latched copy
            eff_glob = (state_q[b] == ST_IDLE) ? req_is_global : glob_q[b];
            eff_size = (state_q[b] == ST_IDLE) ? req_size_m1   : size_q[b];
            new_mask = wmask_q[b] | w_wid_onehot;
            thresh   = eff_glob ? (NUM_WARPS - 1) : int'(eff_size);

            // Cluster accepted the presented global request
            if (w_gsel_found && gbar_req_ready && (w_gsel_id == NB_WIDTH'(b))) begin
                state_d[b] = ST_GWAIT;
            end

            // Cluster released a barrier this entry is waiting on
            if (gbar_rsp_valid && (gbar_rsp_id == NB_WIDTH'(b)) &&
                (state_q[b] == ST_GWAIT)) begin
                rel_valid_d = 1'b1;
                rel_mask_d  = rel_mask_d | wmask_q[b];
                state_d[b]  = ST_IDLE;
                count_d[b]  = '0;
                wmask_d[b]  = '0;
            end

            // Arrival; the ready gate keeps this disjoint from the global phases above
            if (w_accept && !req_is_noop && (req_id == NB_WIDTH'(b)) &&
                ((wmask_q[b] & w_wid_onehot) == '0)) begin
                glob_d[b] = eff_glob;
                size_d[b] = eff_size;
                if (int'(count_q[b]) == thresh) begin
                    if (eff_glob) begin
                        state_d[b] = ST_GREQ;
                        wmask_d[b] = new_mask;
                    end else begin
                        rel_valid_d = 1'b1;
                        rel_mask_d  = rel_mask_d | new_mask;
                        state_d[b]  = ST_IDLE;
                        count_d[b]  = '0;
                        wmask_d[b]  = '0;
                    end
                end else begin
                    state_d[b] = ST_COLLECT;
                    count_d[b] = count_q[b] + (NW_WIDTH+1)'(1);
                    wmask_d[b] = new_mask;
                end
            end
        end
    end

    // Entry and release registers; reset discards all pending barriers silently
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                state_q[b] <= ST_IDLE;
                count_q[b] <= '0;
                wmask_q[b] <= '0;
                glob_q[b]  <= 1'b0;
                size_q[b]  <= '0;
            end
            rel_valid_q <= 1'b0;
            rel_mask_q  <= '0;
        end else begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                state_q[b] <= state_d[b];
                count_q[b] <= count_d[b];
                wmask_q[b] <= wmask_d[b];
                glob_q[b]  <= glob_d[b];
                size_q[b]  <= size_d[b];
            end
            rel_valid_q <= rel_valid_d;
            rel_mask_q  <= rel_mask_d;
        end
    end

    assign req_ready        = w_ready;
    assign release_valid    = rel_valid_q;
    assign release_wmask    = rel_mask_q;
    assign stalled_wmask    = w_stalled;
    assign gbar_req_valid   = w_gsel_found;
    assign gbar_req_id      = w_gsel_id;
    assign gbar_req_size_m1 = w_gsel_size;

endmodule
`default_nettype wire
